keypad_decoder: RTL and testbench

Receiving end of the keypad input encoder's 5-bit code bus. It debounces the encoded code and accepts exactly one key per press/release cycle. It then regenerates a registered one-hot key vector and a one-cycle strobe, and shifts accepted digits into a multi-digit entry buffer. It sits between the input encoder and downstream entry logic such as PIN compare or display.

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/digit_buffer.sv | 56 +++++
 rtl/keypad_decoder.sv | 139 +++++++++++++
 tb/tb_keypad_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad decoder slice: FSM state encoding,
// code-bus field positions and the key-index to one-hot helper.
package keypad_pkg;

    // Debounce/hold FSM states, encoded 0..3 in the order a press walks through them.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } keypad_state_e;

    // Position of the "any key down" flag on the encoder code bus.
    localparam int VALID_BIT = 4;

    // Largest BCD value that maps onto a real key.
    localparam int MAX_DIGIT = 9;

    // Number of physical keys, and so the width of the one-hot vector.
    localparam int KEYS = 10;

    // Returns the one-hot pattern for a key index. Indices above MAX_DIGIT
    // shift the single bit out of range and give all zeros, but callers
    // screen those codes out before using the result.
    function automatic logic [KEYS-1:0] to_onehot(input logic [3:0] idx);
        logic [KEYS-1:0] result;
        result = KEYS'(1) << idx;
        return result;
    endfunction

    // True when a BCD code names one of the ten real keys.
    function automatic logic is_digit_code(input logic [3:0] code);
        return code <= 4'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/digit_buffer.sv
// Multi-digit entry buffer fed by the keypad decoder. Newest digit sits in
// bits 3:0 and older digits move up by one nibble per push. A full buffer
// drops further digits and flags the loss with a one-cycle overflow pulse.
// A synchronous clear always wins over a push on the same edge.
module digit_buffer #(
    parameter int DIGITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           push,
    input  logic [3:0]                     digit,
    output logic [4*DIGITS-1:0]            digits,
    output logic [$clog2(DIGITS+1)-1:0]    digit_count,
    output logic                           full,
    output logic                           overflow
);

    localparam int CW = $clog2(DIGITS + 1);

    logic [4*DIGITS-1:0] shifted;

    // Full is combinational so it tracks digit_count in the same cycle.
    assign full = (digit_count == CW'(DIGITS));

    // Build the next buffer image: everything moves up one nibble and the new
    // digit lands in the bottom nibble. Written this way so DIGITS=1 works too.
    always_comb begin
        shifted      = digits << 4;
        shifted[3:0] = digit;
    end

    // Buffer update with clear taking priority over push, and the overflow
    // pulse raised only for a push that arrives while the buffer is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (clear) begin
                digits      <= '0;
                digit_count <= '0;
            end else if (push) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    digits      <= shifted;
                    digit_count <= digit_count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// Receiving end of the keypad encoder's 5-bit code bus. Debounces the code,
// accepts one key per press/release cycle, drives a registered one-hot key
// vector plus a one-cycle strobe, and feeds accepted digits into the entry
// buffer. Codes above 9 are accepted as presses but only raise code_err.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [4:0]                     code_in,
    input  logic                           clear,
    output logic [KEYS-1:0]                key_onehot,
    output logic                           key_strobe,
    output logic [4*DIGITS-1:0]            digits,
    output logic [$clog2(DIGITS+1)-1:0]    digit_count,
    output logic                           full,
    output logic                           code_err,
    output logic                           overflow
);

    // The counter holds the number of identical samples seen so far, so the
    // sample that completes debouncing is the one arriving at DEBOUNCE_CYCLES-1.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    keypad_state_e state;
    logic [7:0]    db_count;
    logic [3:0]    candidate;

    logic          valid;
    logic [3:0]    key;
    logic          accept;
    logic          release_done;
    logic          cand_is_digit;
    logic          push;

    assign valid = code_in[VALID_BIT];
    assign key   = code_in[3:0];

    // Decode the two debounce-completion events from the current state and
    // sample; accept must be combinational so the buffer pushes on the same
    // edge that the strobe rises.
    always_comb begin
        accept        = 1'b0;
        release_done  = 1'b0;
        cand_is_digit = is_digit_code(candidate);
        if (state == PRESS_DB && valid && key == candidate && db_count == DB_LAST) begin
            accept = 1'b1;
        end
        if (state == REL_DB && !valid && db_count == DB_LAST) begin
            release_done = 1'b1;
        end
        push = accept && cand_is_digit;
    end

    // Debounce FSM with registered one-hot, strobe and code-error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            db_count   <= 8'd0;
            candidate  <= 4'd0;
            key_onehot <= '0;
            key_strobe <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            code_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        state     <= PRESS_DB;
                        db_count  <= 8'd1;
                        candidate <= key;
                    end
                end
                PRESS_DB: begin
                    if (!valid) begin
                        state    <= IDLE;
                        db_count <= 8'd0;
                    end else if (key != candidate) begin
                        candidate <= key;
                        db_count  <= 8'd1;
                    end else if (accept) begin
                        state      <= HELD;
                        db_count   <= 8'd0;
                        key_strobe <= 1'b1;
                        if (cand_is_digit) begin
                            key_onehot <= to_onehot(candidate);
                        end else begin
                            key_onehot <= '0;
                            code_err   <= 1'b1;
                        end
                    end else begin
                        db_count <= db_count + 8'd1;
                    end
                end
                HELD: begin
                    if (!valid) begin
                        state    <= REL_DB;
                        db_count <= 8'd1;
                    end
                end
                REL_DB: begin
                    if (valid) begin
                        state    <= HELD;
                        db_count <= 8'd0;
                    end else if (release_done) begin
                        state      <= IDLE;
                        db_count   <= 8'd0;
                        key_onehot <= '0;
                    end else begin
                        db_count <= db_count + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    db_count <= 8'd0;
                end
            endcase
        end
    end

    digit_buffer #(
        .DIGITS(DIGITS)
    ) u_digit_buffer (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .push        (push),
        .digit       (candidate),
        .digits      (digits),
        .digit_count (digit_count),
        .full        (full),
        .overflow    (overflow)
    );

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder with a run-length behavioural model that
// is checked against the DUT on every falling edge, plus literal checks of
// the hand-worked scenarios.
module tb_keypad_decoder;

    localparam int D  = 4;
    localparam int ND = 4;
    localparam int CW = $clog2(ND + 1);

    logic              clk;
    logic              rst;
    logic [4:0]        code_in;
    logic              clear;
    logic [9:0]        key_onehot;
    logic              key_strobe;
    logic [4*ND-1:0]   digits;
    logic [CW-1:0]     digit_count;
    logic              full;
    logic              code_err;
    logic              overflow;

    int vectors;
    int miscompares;
    int strobe_cnt;

    // Model state: whether a key is currently accepted, length of the current
    // run of relevant samples, the key of that run, and the stored digits.
    bit          m_down;
    int          m_run;
    int          m_cand;
    int          m_q[$];
    logic [9:0]  e_onehot;
    bit          e_strobe;
    bit          e_err;
    bit          e_ovf;

    keypad_decoder #(
        .DEBOUNCE_CYCLES(D),
        .DIGITS(ND)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .clear       (clear),
        .key_onehot  (key_onehot),
        .key_strobe  (key_strobe),
        .digits      (digits),
        .digit_count (digit_count),
        .full        (full),
        .code_err    (code_err),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hold one input pattern for n sampling edges; returns just after the
    // falling edge that follows the last of them.
    task automatic applyStimulus(input logic [4:0] code, input logic clr, input int n);
        for (int i = 0; i < n; i++) begin
            code_in = code;
            clear   = clr;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pressKey(input int k);
        applyStimulus({1'b1, 4'(k)}, 1'b0, D);
    endtask

    task automatic releaseKey();
        applyStimulus(5'b00000, 1'b0, D + 1);
    endtask

    function automatic logic [4*ND-1:0] model_digits();
        logic [4*ND-1:0] v;
        v = '0;
        foreach (m_q[i]) v = (v << 4) | (4*ND)'(m_q[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_down   = 0;
        m_run    = 0;
        m_cand   = 0;
        m_q.delete();
        e_onehot = '0;
        e_strobe = 0;
        e_err    = 0;
        e_ovf    = 0;
    endtask

    // One sampling edge of the model: count runs of identical valid samples
    // while no key is held, and runs of invalid samples while one is.
    task automatic model_step(input logic [4:0] c, input logic clr);
        bit valid;
        bit push;
        int k;
        valid    = c[4];
        k        = int'(c[3:0]);
        e_strobe = 0;
        e_err    = 0;
        e_ovf    = 0;
        push     = 0;
        if (!m_down) begin
            if (valid) begin
                if (m_run > 0 && k == m_cand) m_run++;
                else begin
                    m_run  = 1;
                    m_cand = k;
                end
                if (m_run == D) begin
                    m_down   = 1;
                    m_run    = 0;
                    e_strobe = 1;
                    if (m_cand <= 9) begin
                        e_onehot = 10'(1) << m_cand;
                        push     = 1;
                    end else begin
                        e_onehot = '0;
                        e_err    = 1;
                    end
                end
            end else m_run = 0;
        end else begin
            if (!valid) begin
                m_run++;
                if (m_run == D) begin
                    m_down   = 0;
                    m_run    = 0;
                    e_onehot = '0;
                end
            end else m_run = 0;
        end
        if (clr) m_q.delete();
        else if (push) begin
            if (m_q.size() == ND) e_ovf = 1;
            else m_q.push_back(m_cand);
        end
    endtask

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (rst) model_reset();
        else begin
            model_step(code_in, clear);
            checkOutput("onehot", 32'(key_onehot), 32'(e_onehot));
            checkOutput("strobe", 32'(key_strobe), 32'(e_strobe));
            checkOutput("code_err", 32'(code_err), 32'(e_err));
            checkOutput("overflow", 32'(overflow), 32'(e_ovf));
            checkOutput("digits", 32'(digits), 32'(model_digits()));
            checkOutput("count", 32'(digit_count), 32'(m_q.size()));
            checkOutput("full", 32'(full), 32'(m_q.size() == ND));
            if (key_strobe) strobe_cnt++;
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        strobe_cnt  = 0;
        model_reset();
        rst     = 1'b1;
        code_in = 5'b00000;
        clear   = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_onehot", 32'(key_onehot), 32'h0);
        checkOutput("rst_digits", 32'(digits), 32'h0);
        checkOutput("rst_count", 32'(digit_count), 32'h0);
        checkOutput("rst_full", 32'(full), 32'h0);
        $display("[TB] single press of key 5");
        strobe_cnt = 0;
        applyStimulus(5'b10101, 1'b0, 3);
        checkOutput("k5_early_strobe", 32'(key_strobe), 32'h0);
        applyStimulus(5'b10101, 1'b0, 1);
        checkOutput("k5_strobe", 32'(key_strobe), 32'h1);
        checkOutput("k5_onehot", 32'(key_onehot), 32'h020);
        checkOutput("k5_digits", 32'(digits), 32'h0005);
        checkOutput("k5_count", 32'(digit_count), 32'h1);
        applyStimulus(5'b10101, 1'b0, 2);
        checkOutput("k5_hold_onehot", 32'(key_onehot), 32'h020);
        applyStimulus(5'b00000, 1'b0, 3);
        checkOutput("k5_rel3_onehot", 32'(key_onehot), 32'h020);
        applyStimulus(5'b00000, 1'b0, 1);
        checkOutput("k5_rel4_onehot", 32'(key_onehot), 32'h000);
        applyStimulus(5'b00000, 1'b0, 2);
        checkOutput("k5_strobes", 32'(strobe_cnt), 32'h1);
        $display("[TB] bounce on press and on hold");
        applyStimulus(5'b00000, 1'b1, 1);
        strobe_cnt = 0;
        applyStimulus(5'b10011, 1'b0, 2);
        applyStimulus(5'b00000, 1'b0, 1);
        applyStimulus(5'b10011, 1'b0, 3);
        checkOutput("b_no_early", 32'(strobe_cnt), 32'h0);
        applyStimulus(5'b10011, 1'b0, 1);
        checkOutput("b_strobe", 32'(key_strobe), 32'h1);
        checkOutput("b_onehot", 32'(key_onehot), 32'h008);
        applyStimulus(5'b00000, 1'b0, 1);
        applyStimulus(5'b10011, 1'b0, 2);
        checkOutput("b_hold_strobes", 32'(strobe_cnt), 32'h1);
        checkOutput("b_hold_onehot", 32'(key_onehot), 32'h008);
        releaseKey();
        $display("[TB] fill buffer and overflow");
        applyStimulus(5'b00000, 1'b1, 1);
        for (int k = 1; k <= 5; k++) begin
            pressKey(k);
            if (k == 4) begin
                checkOutput("f_digits4", 32'(digits), 32'h1234);
                checkOutput("f_full4", 32'(full), 32'h1);
            end
            if (k == 5) begin
                checkOutput("f_overflow", 32'(overflow), 32'h1);
                checkOutput("f_digits5", 32'(digits), 32'h1234);
            end
            releaseKey();
        end
        $display("[TB] out-of-range code");
        applyStimulus(5'b11100, 1'b0, 4);
        checkOutput("e_strobe", 32'(key_strobe), 32'h1);
        checkOutput("e_err", 32'(code_err), 32'h1);
        checkOutput("e_onehot", 32'(key_onehot), 32'h0);
        checkOutput("e_count", 32'(digit_count), 32'h4);
        checkOutput("e_overflow", 32'(overflow), 32'h0);
        applyStimulus(5'b11100, 1'b0, 1);
        releaseKey();
        $display("[TB] clear on accept edge");
        applyStimulus(5'b00000, 1'b1, 1);
        pressKey(1);
        releaseKey();
        pressKey(2);
        releaseKey();
        checkOutput("c_pre_count", 32'(digit_count), 32'h2);
        applyStimulus(5'b10111, 1'b0, 3);
        applyStimulus(5'b10111, 1'b1, 1);
        checkOutput("c_digits", 32'(digits), 32'h0);
        checkOutput("c_count", 32'(digit_count), 32'h0);
        checkOutput("c_strobe", 32'(key_strobe), 32'h1);
        checkOutput("c_onehot", 32'(key_onehot), 32'h080);
        checkOutput("c_overflow", 32'(overflow), 32'h0);
        applyStimulus(5'b10111, 1'b0, 1);
        releaseKey();
        $display("[TB] reset during press debounce");
        pressKey(8);
        releaseKey();
        checkOutput("r_pre_digits", 32'(digits), 32'h0008);
        applyStimulus(5'b10110, 1'b0, 3);
        rst = 1'b1;
        #1;
        checkOutput("r_digits", 32'(digits), 32'h0);
        checkOutput("r_count", 32'(digit_count), 32'h0);
        checkOutput("r_onehot", 32'(key_onehot), 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        strobe_cnt = 0;
        applyStimulus(5'b10110, 1'b0, 3);
        checkOutput("r_no_early", 32'(strobe_cnt), 32'h0);
        applyStimulus(5'b10110, 1'b0, 1);
        checkOutput("r_strobe", 32'(key_strobe), 32'h1);
        checkOutput("r_onehot6", 32'(key_onehot), 32'h040);
        checkOutput("r_digits6", 32'(digits), 32'h0006);
        releaseKey();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
